// File: rtl/dvp_emu_pkg.sv
// Shared types and constants for the DVP sensor emulator.
//   state_t     : frame sequencer states
//   PAT_*       : pattern_sel encodings
//   imax        : constant helper for sizing the line counter
package dvp_emu_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VSYNC  = 3'd1,
      VBACK  = 3'd2,
      ACTIVE = 3'd3,
      VFRONT = 3'd4
   } state_t;

   localparam logic [1:0] PAT_HRAMP = 2'd0;
   localparam logic [1:0] PAT_VRAMP = 2'd1;
   localparam logic [1:0] PAT_CHECK = 2'd2;
   localparam logic [1:0] PAT_MOVE  = 2'd3;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dvp_sensor_emulator_pattern.sv
// Registered test-pattern pixel generator.
//   clk, rst_n : pixel clock, async active-low reset
//   valid      : pixel is active in the next cycle (next-state href)
//   x, y       : next-cycle pixel column / active line index (8-bit truncated)
//   frame_cnt  : completed-frame count, used by the moving ramp
//   pattern    : pattern code latched for the current frame
//   data       : registered pixel, 8'h00 whenever valid was low
// Macro DVP_FRAME_STAMP_EN: pixel (0,0) of each frame carries frame_cnt.
module dvp_pattern_gen
   import dvp_emu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       valid,
   input  logic [7:0] x,
   input  logic [7:0] y,
   input  logic [7:0] frame_cnt,
   input  logic [1:0] pattern,
   output logic [7:0] data
);

   logic [7:0] pix;

   always_comb begin
      pix = 8'h00;
      case (pattern)
         PAT_HRAMP: pix = x;
         PAT_VRAMP: pix = y;
         PAT_CHECK: pix = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
         PAT_MOVE:  pix = x + frame_cnt;
         default:   pix = 8'h00;
      endcase
`ifdef DVP_FRAME_STAMP_EN
      if (x == 8'd0 && y == 8'd0)
         pix = frame_cnt;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         data <= 8'h00;
      else
         data <= valid ? pix : 8'h00;
   end

endmodule

// File: rtl/dvp_sensor_emulator.sv
// DVP parallel-bus sensor emulator: frame sequencer plus test-pattern source.
// Ports:
//   clk, rst_n   : pixel clock, async active-low reset
//   enable       : run request, sampled only at frame boundaries
//   pattern_sel  : 0 h-ramp, 1 v-ramp, 2 checker, 3 moving ramp (latched per frame)
//   cmos_vsync   : high during VSYNC lines
//   cmos_href    : high while cmos_data holds an active pixel
//   cmos_data    : pixel value, 8'h00 when href is low
//   frame_start  : one-cycle pulse with the first vsync-high cycle
//   frame_cnt    : completed frames, wraps at 256
//   busy         : sequencer not idle
// Optional macro DVP_FRAME_STAMP_EN (see dvp_pattern_gen).
//
// state  | meaning
// IDLE   | waiting for enable, bus quiet
// VSYNC  | VSYNC_LINES lines with vsync high
// VBACK  | V_BACK blank lines before the first active line
// ACTIVE | V_ACTIVE lines, href for the first H_ACTIVE cycles of each
// VFRONT | V_FRONT blank lines; last cycle ends the frame
//
// All pins are registered from next-state/next-counter values so they move on
// the same edge the sequencer changes state.
module dvp_sensor_emulator
   import dvp_emu_pkg::*;
#(
   parameter int H_ACTIVE    = 752,
   parameter int H_BLANK     = 94,
   parameter int V_ACTIVE    = 480,
   parameter int VSYNC_LINES = 2,
   parameter int V_BACK      = 4,
   parameter int V_FRONT     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] pattern_sel,
   output logic       cmos_vsync,
   output logic       cmos_href,
   output logic [7:0] cmos_data,
   output logic       frame_start,
   output logic [7:0] frame_cnt,
   output logic       busy
);

   localparam int H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int V_MAX   = imax(imax(VSYNC_LINES, V_BACK), imax(V_ACTIVE, V_FRONT));
   localparam int VW      = (V_MAX > 1) ? $clog2(V_MAX) : 1;

   localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_N = HW'(H_ACTIVE);
   localparam logic [VW-1:0] VS_LAST = VW'(VSYNC_LINES - 1);
   localparam logic [VW-1:0] VB_LAST = VW'(V_BACK - 1);
   localparam logic [VW-1:0] VA_LAST = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] VF_LAST = VW'(V_FRONT - 1);

   if (H_ACTIVE < 1 || H_BLANK < 1 || V_ACTIVE < 1 || VSYNC_LINES < 1 ||
       V_BACK < 0 || V_FRONT < 0) begin : g_bad_params
      $error("dvp_sensor_emulator: H_ACTIVE, H_BLANK, V_ACTIVE, VSYNC_LINES must be >= 1");
   end

   state_t          state, state_nxt;
   logic [HW-1:0]   h_cnt, h_nxt;
   logic [VW-1:0]   v_cnt, v_nxt;
   logic [1:0]      pat_q;
   logic            line_end;
   logic            frame_done;
   logic            start_nxt;
   logic            href_nxt;

   always_comb begin
      state_nxt  = state;
      h_nxt      = h_cnt;
      v_nxt      = v_cnt;
      frame_done = 1'b0;
      line_end   = (h_cnt == H_LAST);
      if (state == IDLE) begin
         h_nxt = '0;
         v_nxt = '0;
         if (enable)
            state_nxt = VSYNC;
      end else begin
         h_nxt = line_end ? '0 : h_cnt + 1'b1;
         if (line_end) begin
            v_nxt = v_cnt + 1'b1;
            case (state)
               VSYNC: begin
                  if (v_cnt == VS_LAST) begin
                     if (V_BACK > 0) state_nxt = VBACK;
                     else            state_nxt = ACTIVE;
                  end
               end
               VBACK: begin
                  if (v_cnt == VB_LAST)
                     state_nxt = ACTIVE;
               end
               ACTIVE: begin
                  if (v_cnt == VA_LAST) begin
                     if (V_FRONT > 0) state_nxt = VFRONT;
                     else             frame_done = 1'b1;
                  end
               end
               VFRONT: begin
                  if (v_cnt == VF_LAST)
                     frame_done = 1'b1;
               end
               default: state_nxt = IDLE;
            endcase
            // enable only matters here and in IDLE: frames are never cut short
            if (frame_done) begin
               if (enable) state_nxt = VSYNC;
               else        state_nxt = IDLE;
            end
            if (state_nxt != state)
               v_nxt = '0;
         end
      end
   end

   assign start_nxt = (state_nxt == VSYNC) && (state != VSYNC);
   assign href_nxt  = (state_nxt == ACTIVE) && (h_nxt < H_ACT_N);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         h_cnt       <= '0;
         v_cnt       <= '0;
         pat_q       <= PAT_HRAMP;
         frame_cnt   <= 8'd0;
         cmos_vsync  <= 1'b0;
         cmos_href   <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         h_cnt       <= h_nxt;
         v_cnt       <= v_nxt;
         if (start_nxt)
            pat_q <= pattern_sel;
         if (frame_done)
            frame_cnt <= frame_cnt + 8'd1;
         cmos_vsync  <= (state_nxt == VSYNC);
         cmos_href   <= href_nxt;
         frame_start <= start_nxt;
         busy        <= (state_nxt != IDLE);
      end
   end

   dvp_pattern_gen u_pattern (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (href_nxt),
      .x         (8'(h_nxt)),
      .y         (8'(v_nxt)),
      .frame_cnt (frame_cnt),
      .pattern   (pat_q),
      .data      (cmos_data)
   );

endmodule

// File: tb/tb_dvp_sensor_emulator.sv
// Directed bench for dvp_sensor_emulator with a small frame geometry:
// H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1
// (12-cycle lines, 84-cycle frames). Honours DVP_FRAME_STAMP_EN.
module tb_dvp_sensor_emulator;

   localparam int FRAME_LEN = 84;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [1:0] pattern_sel;
   logic       cmos_vsync;
   logic       cmos_href;
   logic [7:0] cmos_data;
   logic       frame_start;
   logic [7:0] frame_cnt;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dvp_sensor_emulator #(
      .H_ACTIVE    (8),
      .H_BLANK     (4),
      .V_ACTIVE    (4),
      .VSYNC_LINES (1),
      .V_BACK      (1),
      .V_FRONT     (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .pattern_sel (pattern_sel),
      .cmos_vsync  (cmos_vsync),
      .cmos_href   (cmos_href),
      .cmos_data   (cmos_data),
      .frame_start (frame_start),
      .frame_cnt   (frame_cnt),
      .busy        (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_pix(input logic [1:0] pat, input int x, input int y,
                                          input logic [7:0] fc);
      logic [7:0] xv, yv, r;
      xv = x[7:0];
      yv = y[7:0];
      case (pat)
         2'd0:    r = xv;
         2'd1:    r = yv;
         2'd2:    r = (xv[3] ^ yv[3]) ? 8'hFF : 8'h00;
         default: r = xv + fc;
      endcase
`ifdef DVP_FRAME_STAMP_EN
      if (x == 0 && y == 0) r = fc;
`endif
      return r;
   endfunction

   // Precondition: the next rising edge starts the frame (IDLE with enable=1,
   // or the final VFRONT cycle of the previous frame with enable=1).
   task automatic run_frame(input logic [1:0] pat, input logic [7:0] fc,
                            input int chg_at, input logic [1:0] chg_pat, input int drop_at);
      for (int t = 0; t < FRAME_LEN; t++) begin
         logic       e_vs, e_hr;
         logic [7:0] e_d;
         int         x, y;
         tick();
         e_vs = (t < 12);
         e_hr = 1'b0;
         e_d  = 8'h00;
         if (t >= 24 && t < 72) begin
            x = (t - 24) % 12;
            y = (t - 24) / 12;
            if (x < 8) begin
               e_hr = 1'b1;
               e_d  = exp_pix(pat, x, y, fc);
            end
         end
         chk($sformatf("vsync t=%0d fc=%0d", t, fc), cmos_vsync, e_vs);
         chk($sformatf("fstart t=%0d fc=%0d", t, fc), frame_start, (t == 0));
         chk($sformatf("href t=%0d fc=%0d", t, fc), cmos_href, e_hr);
         chk($sformatf("data t=%0d fc=%0d", t, fc), cmos_data, e_d);
         chk($sformatf("busy t=%0d fc=%0d", t, fc), busy, 1'b1);
         chk($sformatf("fcnt t=%0d fc=%0d", t, fc), frame_cnt, fc);
         if (t == chg_at)  pattern_sel = chg_pat;
         if (t == drop_at) enable = 1'b0;
      end
   endtask

   task automatic idle_check(input int cycles, input logic [7:0] fc);
      for (int i = 0; i < cycles; i++) begin
         tick();
         chk($sformatf("idle_busy i=%0d", i), busy, 1'b0);
         chk($sformatf("idle_vsync i=%0d", i), cmos_vsync, 1'b0);
         chk($sformatf("idle_href i=%0d", i), cmos_href, 1'b0);
         chk($sformatf("idle_fstart i=%0d", i), frame_start, 1'b0);
         chk($sformatf("idle_data i=%0d", i), cmos_data, 8'h00);
         chk($sformatf("idle_fcnt i=%0d", i), frame_cnt, fc);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      enable      = 1'b0;
      pattern_sel = 2'd0;
      repeat (3) tick();
      chk("rst_vsync", cmos_vsync, 1'b0);
      chk("rst_href", cmos_href, 1'b0);
      chk("rst_data", cmos_data, 8'h00);
      chk("rst_fstart", frame_start, 1'b0);
      chk("rst_fcnt", frame_cnt, 8'd0);
      chk("rst_busy", busy, 1'b0);

      // enable held off after release: stays idle
      rst_n = 1'b1;
      idle_check(5, 8'd0);

      // frame 0 h-ramp; pattern_sel changes mid-ACTIVE but frame stays h-ramp
      enable = 1'b1;
      run_frame(2'd0, 8'd0, 50, 2'd1, -1);
      // frame 1 v-ramp, back-to-back; switch to moving ramp during vsync
      run_frame(2'd1, 8'd1, 5, 2'd3, -1);
      // frames 2..4 moving ramp; enable dropped during ACTIVE of the last
      run_frame(2'd3, 8'd2, -1, 2'd3, -1);
      run_frame(2'd3, 8'd3, -1, 2'd3, -1);
      run_frame(2'd3, 8'd4, -1, 2'd3, 30);
      idle_check(20, 8'd5);

      // ramp frame with pattern_sel 0->2 mid-frame, then checker frame
      pattern_sel = 2'd0;
      enable      = 1'b1;
      run_frame(2'd0, 8'd5, 40, 2'd2, -1);
      run_frame(2'd2, 8'd6, -1, 2'd2, -1);

      // frame 7 starts; reset mid-line during the first active line
      pattern_sel = 2'd0;
      repeat (30) tick();
      chk("pre_rst_href", cmos_href, 1'b1);
      chk("pre_rst_fcnt", frame_cnt, 8'd7);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_href", cmos_href, 1'b0);
      chk("mid_rst_vsync", cmos_vsync, 1'b0);
      chk("mid_rst_data", cmos_data, 8'h00);
      chk("mid_rst_fcnt", frame_cnt, 8'd0);
      chk("mid_rst_busy", busy, 1'b0);
      repeat (2) tick();
      rst_n = 1'b1;
      run_frame(2'd0, 8'd0, -1, 2'd0, 10);
      idle_check(10, 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dvp_sensor_emulator.md
Name: dvp_sensor_emulator

Overview:
- Synthesisable DVP-side source that plays the role of an MT9V034-class sensor on the parallel pixel bus: drives cmos_vsync, cmos_href and 8-bit cmos_data with configurable frame timing and test patterns.
- Drives the capture/zoom path directly, on-chip, in place of the physical sensor. Used for bring-up and regression of the downstream gray-image pipeline without silicon.

Parameters:
- H_ACTIVE, 752, pixels per active line (href high cycles).
- H_BLANK, 94, href-low cycles after each active segment; line length H_TOTAL = H_ACTIVE + H_BLANK.
- V_ACTIVE, 480, active lines per frame.
- VSYNC_LINES, 2, lines with cmos_vsync high.
- V_BACK, 4, blank lines between vsync fall and first active line.
- V_FRONT, 4, blank lines after the last active line.

Ports:
- clk, input, 1, pixel clock; all logic on rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- enable, input, 1, run request; sampled at frame boundaries only.
- pattern_sel, input, 2, test pattern: 0 h-ramp, 1 v-ramp, 2 checker, 3 moving ramp.
- cmos_vsync, output, 1, high during the VSYNC interval.
- cmos_href, output, 1, high while cmos_data carries an active pixel.
- cmos_data, output, 8, pixel value; 8'h00 whenever href is low.
- frame_start, output, 1, one-cycle pulse coincident with the first cycle of cmos_vsync high.
- frame_cnt, output, 8, completed-frame counter; wraps 255 -> 0.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- Outputs are registered and decoded from next-state/counters, so pins change exactly at state-boundary edges.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
- Counters: h_cnt counts 0..H_TOTAL-1 in every non-IDLE state. v_cnt counts lines within the current state and clears on each state change.
- IDLE -> VSYNC on an edge where enable = 1.
  - cmos_vsync and frame_start are high in the cycle after that edge (1-cycle latency).
  - pattern_sel is latched on the same edge; it is constant for the whole frame.
- VSYNC lasts VSYNC_LINES*H_TOTAL cycles, then VBACK for V_BACK*H_TOTAL cycles.
- ACTIVE lasts V_ACTIVE lines. In each line, href = 1 for h_cnt 0..H_ACTIVE-1, then href = 0 for H_BLANK cycles.
- Pixel value (x = h_cnt, y = active line index):
  - pattern 0: x[7:0]
  - pattern 1: y[7:0]
  - pattern 2: 8'hFF when x[3]^y[3], else 8'h00
  - pattern 3: (x + frame_cnt) mod 256
- VFRONT lasts V_FRONT*H_TOTAL cycles. On its last cycle:
  - frame_cnt increments (mod 256);
  - if enable = 1, go to VSYNC directly (back-to-back frames, no idle gap); otherwise go to IDLE.
- enable deasserted mid-frame: the current frame always completes. There are no truncated frames.
- Zero-length parameters: V_BACK = 0 or V_FRONT = 0 skips that state. VSYNC_LINES, V_ACTIVE, H_ACTIVE and H_BLANK must be >= 1 (elaboration error otherwise).
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronously); frame_cnt clears; the next frame starts from VSYNC.
- Width rules: h_cnt and v_cnt widths come from $clog2 of their maxima. Pixel arithmetic truncates to 8 bits.

Optional Feature:
- Macro DVP_FRAME_STAMP_EN.
- Defined: the first active pixel of each frame (y = 0, x = 0) is replaced by the frame_cnt value, so the sink can check frame ordering.
- Undefined: that pixel carries the normal pattern value. No extra logic.

Decomposition:
- Package dvp_emu_pkg holds:
  - state enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT);
  - pattern code localparams PAT_HRAMP = 0, PAT_VRAMP = 1, PAT_CHECK = 2, PAT_MOVE = 3.
- Sub-module dvp_pattern_gen computes the registered pixel value from x, y, frame_cnt and the latched pattern.
- The top level holds the FSM and counters.

Test Plan (H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1; H_TOTAL=12):
- Reset release, enable=1, pattern 0 -> vsync high 12 cycles; 12 blank cycles; 4 lines each of 8 href cycles with data 0..7 plus 4 low cycles; 12 blank; frame_cnt=1; total 84 cycles per frame.
- Pattern 1 -> every pixel in line y equals y (0..3); data is 0 on every href-low cycle.
- Pattern 3 over 3 back-to-back frames -> first pixel of each line equals 0, 1, 2 (frame_cnt); no IDLE gap; frame_start pulses every 84 cycles.
- enable dropped during ACTIVE of frame 0 -> frame completes, busy falls after VFRONT, frame_cnt=1, vsync stays 0.
- pattern_sel changed 0->2 mid-frame -> current frame stays ramp; next frame shows checker, with 8'hFF starting at x=8 (outside the 8-wide line, so each line is all 00 for y<8).
- rst_n pulsed low mid-line -> href, vsync, data and frame_cnt are 0 immediately; after release with enable=1, vsync reasserts after 1 cycle.
- With DVP_FRAME_STAMP_EN, pattern 0 -> pixel (0,0) of frame n equals n; all other pixels unchanged.
